alu_mul_sequencer: RTL and testbench

//   Multi-cycle controller that computes a WIDTH-bit product (low WIDTH bits of A*B) using only the shared 16-bit ALU.
//   It steps the ALU through ADD, SLL and SRL operations in a shift-add loop, one ALU operation per clock.

---
 rtl/alu_mul_sequencer_if.sv | 27 ++
 rtl/alu_mul_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Request, response and ALU-drive signals of the shift-add multiply sequencer.
// The sequencer connects through the slave modport; its issue side and the ALU connect through master.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_prod;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_s;

  modport master (
    output in_valid, in_a, in_b, out_ready, alu_s,
    input  in_ready, out_valid, out_prod, alu_a, alu_b, alu_op
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready, alu_s,
    output in_ready, out_valid, out_prod, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multiplier that borrows the shared ALU, one ADD/SLL/SRL per clock in a shift-add loop.
// Returns the low WIDTH bits of a*b, so signed and unsigned operands give the same result.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   st_idle | ready for a request; an accept loads operands, clears acc
//   st_step | finish when mplier is zero, otherwise pick ADD or SHL
//   st_add  | acc <= acc + mcand
//   st_shl  | mcand <= mcand << 1
//   st_shr  | mplier <= mplier >> 1
//   st_done | product held on out_prod until out_ready
module alu_mul_sequencer #(
  parameter int         WIDTH  = 16,
  parameter logic [3:0] OP_ADD = 4'b0011,
  parameter logic [3:0] OP_SLL = 4'b0101,
  parameter logic [3:0] OP_SRL = 4'b0111
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_mul_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    st_idle,
    st_step,
    st_add,
    st_shl,
    st_shr,
    st_done
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= st_idle;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (bus.in_valid) begin
            mcand      <= bus.in_a;
            mplier     <= bus.in_b;
            acc        <= '0;
            in_ready_q <= 1'b0;
            state      <= st_step;
          end
        end
        st_step: begin
          // An exhausted multiplier ends the loop, so no iteration counter is needed.
          if (mplier == '0) begin
            out_valid_q <= 1'b1;
            out_prod_q  <= acc;
            state       <= st_done;
          end else if (mplier[0]) begin
            state <= st_add;
          end else begin
            state <= st_shl;
          end
        end
        st_add: begin
          acc   <= bus.alu_s;
          state <= st_shl;
        end
        st_shl: begin
          mcand <= bus.alu_s;
          state <= st_shr;
        end
        st_shr: begin
          mplier <= bus.alu_s;
          state  <= st_step;
        end
        st_done: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= st_idle;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state       <= st_idle;
        end
      endcase
    end
  end

  // The ALU returns its result in the same cycle, so its inputs must be combinational.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = OP_ADD;
    case (state)
      st_add: begin
        bus.alu_a  = acc;
        bus.alu_b  = mcand;
        bus.alu_op = OP_ADD;
      end
      st_shl: begin
        bus.alu_a  = mcand;
        bus.alu_b  = WIDTH'(1);
        bus.alu_op = OP_SLL;
      end
      st_shr: begin
        bus.alu_a  = mplier;
        bus.alu_b  = WIDTH'(1);
        bus.alu_op = OP_SRL;
      end
      default: begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = OP_ADD;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: a vector table of products and latencies plus
// hand-written ALU-sequence, backpressure and mid-operation reset sequences.
module tb_alu_mul_sequencer;

  localparam int         WIDTH  = 16;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0111;

  logic clk;
  logic rst_n;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_sequencer #(
    .WIDTH (WIDTH),
    .OP_ADD(OP_ADD),
    .OP_SLL(OP_SLL),
    .OP_SRL(OP_SRL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU shared with the sequencer.
  always_comb begin
    bus.alu_s = '0;
    case (bus.alu_op)
      OP_ADD:  bus.alu_s = bus.alu_a + bus.alu_b;
      OP_SLL:  bus.alu_s = bus.alu_a << bus.alu_b[3:0];
      OP_SRL:  bus.alu_s = bus.alu_a >> bus.alu_b[3:0];
      default: bus.alu_s = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;

  bit         log_en = 1'b0;
  logic [3:0] ops[$];
  always @(negedge clk)
    if (log_en && bus.alu_b != '0) ops.push_back(bus.alu_op);

  bit watch = 1'b0;
  bit ever_valid;
  always @(negedge clk)
    if (!watch) ever_valid = 1'b0;
    else if (bus.out_valid) ever_valid = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one request and count edges, accept edge included, until out_valid rises.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] prod, output int lat);
    @(negedge clk);
    check("in_ready before accept", 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = bus.out_prod;
  endtask

  task automatic retire();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid after retire", 32'(bus.out_valid), 32'd0);
    check("in_ready after retire", 32'(bus.in_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] prod;
    int          lat;
    logic [3:0]  exp_ops[6];

    vecs[0] = '{16'h1234, 16'h0000, 16'h0000, 2};
    vecs[1] = '{16'h0005, 16'h0003, 16'h000F, 10};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001, 66};
    vecs[3] = '{16'h0003, 16'h0004, 16'h000C, 12};
    vecs[4] = '{16'h00FF, 16'h0101, 16'hFFFF, 31};
    vecs[5] = '{16'hFFFE, 16'h0003, 16'hFFFA, 10};
    vecs[6] = '{16'h8000, 16'h0002, 16'h0000, 9};
    vecs[7] = '{16'h0100, 16'h0100, 16'h0000, 30};

    exp_ops = '{OP_ADD, OP_SLL, OP_SRL, OP_ADD, OP_SLL, OP_SRL};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_prod", 32'(bus.out_prod), 32'd0);
    check("reset alu_op", 32'(bus.alu_op), 32'(OP_ADD));
    check("reset alu_a", 32'(bus.alu_a), 32'd0);
    check("reset alu_b", 32'(bus.alu_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready after reset release", 32'(bus.in_ready), 32'd1);
    check("out_valid after reset release", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].a, vecs[i].b, prod, lat);
      check($sformatf("vec%0d prod", i), 32'(prod), 32'(vecs[i].prod));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      retire();
    end

    // ALU operation order for 5*3.
    log_en = 1'b1;
    run_mul(16'h0005, 16'h0003, prod, lat);
    log_en = 1'b0;
    check("op seq prod", 32'(prod), 32'h000F);
    check("op seq length", 32'(ops.size()), 32'd6);
    for (int i = 0; i < 6 && i < ops.size(); i++)
      check($sformatf("op seq [%0d]", i), 32'(ops[i]), 32'(exp_ops[i]));
    retire();

    // Backpressure in DONE with a competing request held on the input.
    run_mul(16'h0009, 16'h0002, prod, lat);
    check("bp prod", 32'(prod), 32'h0012);
    check("bp latency", 32'(lat), 32'd9);
    @(negedge clk);
    bus.in_a     = 16'h0055;
    bus.in_b     = 16'h0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d out_prod", i), 32'(bus.out_prod), 32'h0012);
      check($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("turnaround out_valid", 32'(bus.out_valid), 32'd0);
    check("turnaround in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("held request accepted", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("held request out_valid", 32'(bus.out_valid), 32'd1);
    check("held request prod", 32'(bus.out_prod), 32'h0000);
    retire();

    // Reset in the middle of a long multiply.
    watch = 1'b1;
    @(negedge clk);
    bus.in_a     = 16'h0007;
    bus.in_b     = 16'h8000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort alu_a", 32'(bus.alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort no out_valid pulse", 32'(ever_valid), 32'd0);
    watch = 1'b0;
    run_mul(16'h0003, 16'h0004, prod, lat);
    check("post-abort prod", 32'(prod), 32'h000C);
    check("post-abort latency", 32'(lat), 32'd12);
    retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
